// File: rtl/fft_unload_pkg.sv
// Shared FFT definitions: default widths, unload FSM state encoding and
// an address bit-reverse helper.
// Latency: n/a (declarations only). Backpressure: n/a.
package fft_unload_pkg;

  localparam int FFT_BIT_WIDTH = 16;  // real/imag sample word width
  localparam int FFT_N         = 9;   // log2 of FFT points (512)

  typedef enum logic [1:0] {
    ST_IDLE,   // waiting for a rising fft_done
    ST_READ,   // issuing RAM reads
    ST_DRAIN,  // every read issued, returned words still buffered
    ST_DONE    // single cycle after the last transfer
  } state_t;

  // Reverse the low 'width' bits of value; bits above width come back as 0.
  function automatic logic [31:0] bit_reverse(input logic [31:0] value,
                                              input int          width);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < width; i++) begin
      r[width-1-i] = value[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_unload_if.sv
// Unload port bundle: fft_done/result_bank trigger, RAM read port and the
// output stream. master = unload engine, slave = its environment.
// Latency: n/a (wiring only). Backpressure: out_ready on the stream side.
interface fft_unload_if
  import fft_unload_pkg::*;
#(
  parameter int BIT_WIDTH = FFT_BIT_WIDTH,
  parameter int N         = FFT_N
);

  // trigger
  logic                 fft_done;
  logic                 result_bank;
  // RAM read port
  logic                 rd_en;
  logic [N-1:0]         rd_addr;
  logic                 rd_sel;
  logic [BIT_WIDTH-1:0] rd_re;
  logic [BIT_WIDTH-1:0] rd_im;
  // output stream
  logic                 out_valid;
  logic                 out_ready;
  logic [BIT_WIDTH-1:0] out_re;
  logic [BIT_WIDTH-1:0] out_im;
  logic [N-1:0]         out_index;
  logic                 out_last;
  logic                 busy;

  modport master (
    input  fft_done, result_bank, rd_re, rd_im, out_ready,
    output rd_en, rd_addr, rd_sel, out_valid, out_re, out_im, out_index,
           out_last, busy
  );

  modport slave (
    output fft_done, result_bank, rd_re, rd_im, out_ready,
    input  rd_en, rd_addr, rd_sel, out_valid, out_re, out_im, out_index,
           out_last, busy
  );

endinterface

// File: rtl/fft_unload_skid_fifo.sv
// Two-entry fall-through FIFO: an incoming word is presented on the same
// cycle it arrives when empty. Latency: 0 cycles when empty, else in order.
// Backpressure: out_ready low holds the head; the writer must never push
// while count==2 (the unload engine keeps its own credit for this).
// Ports: clk/reset, in_valid/in_data (push), out_valid/out_ready/out_data
// (head), count (words stored, excluding a word passing straight through).
module skid_fifo #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem [2];
  logic             rd_ptr;
  logic             wr_ptr;
  logic             empty;
  logic             store;
  logic             deq;

  assign empty     = (count == 2'd0);
  assign out_valid = !empty || in_valid;
  // An arriving word consumed on the spot never needs a storage slot.
  assign store     = in_valid && !(empty && out_ready);
  assign deq       = !empty && out_ready;

  // Zero when nothing is valid so idle/reset outputs read as 0.
  always_comb begin
    out_data = '0;
    if (!empty) begin
      out_data = mem[rd_ptr];
    end else if (in_valid) begin
      out_data = in_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (store) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (deq) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, store} - {1'b0, deq};
    end
  end

endmodule

// File: rtl/fft_unload.sv
// Streams 2^N FFT bins out of the result RAM bank in natural bin order,
// optionally reading addresses in bit-reversed order.
// Latency: start edge t -> rd_en in t+1 -> out_valid in t+2.
// Backpressure: out_ready low stalls the stream; at most two words are ever
// outstanding (buffered + in flight) so nothing is lost or duplicated.
// Ports: clk, reset (async, active high), bus (fft_unload_if.master):
//   fft_done/result_bank trigger, rd_en/rd_addr/rd_sel/rd_re/rd_im RAM port,
//   out_valid/out_ready/out_re/out_im/out_index/out_last stream, busy.
module fft_unload
  import fft_unload_pkg::*;
#(
  parameter int BIT_WIDTH = FFT_BIT_WIDTH,
  parameter int N         = FFT_N,
  parameter bit BIT_REV   = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  fft_unload_if.master bus
);

  localparam int           ENTRY_W  = N + 2 * BIT_WIDTH;
  localparam logic [N-1:0] LAST_BIN = '1;

  state_t               state;
  state_t               state_nx;
  logic                 done_q;      // previous-cycle fft_done
  logic                 bank_q;      // result bank latched at start
  logic [N-1:0]         k_rd;        // next bin to read
  logic                 in_flight;   // a read was issued last cycle
  logic [N-1:0]         flight_idx;  // bin of the read in flight
  logic                 start;
  logic                 rd_issue;
  logic                 busy_c;
  logic [2:0]           occupancy;
  logic [1:0]           fifo_count;
  logic                 head_valid;
  logic [ENTRY_W-1:0]   ret_dat;
  logic [ENTRY_W-1:0]   head_dat;
  logic [N-1:0]         head_idx;
  logic                 head_last;
  logic                 transfer;

  // Only a fresh rising edge seen while idle starts an unload; a level that
  // stays high across the end of an unload cannot retrigger it.
  assign start = (state == ST_IDLE) && bus.fft_done && !done_q;

  // Credit: a slot is reserved for a read as soon as it is issued.
  assign occupancy = {1'b0, fifo_count} + {2'b00, in_flight};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    rd_issue = 1'b0;
    busy_c   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nx = ST_READ;
        end
      end
      ST_READ: begin
        busy_c   = 1'b1;
        rd_issue = (occupancy < 3'd2);
        if (rd_issue && (k_rd == LAST_BIN)) begin
          state_nx = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        busy_c = 1'b1;
        if (transfer && head_last) begin
          state_nx = ST_DONE;
        end
      end
      ST_DONE: begin
        state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done_q     <= 1'b0;
      bank_q     <= 1'b0;
      k_rd       <= '0;
      in_flight  <= 1'b0;
      flight_idx <= '0;
    end else begin
      done_q    <= bus.fft_done;
      in_flight <= rd_issue;
      if (start) begin
        bank_q <= bus.result_bank;
        k_rd   <= '0;
      end else if (rd_issue) begin
        k_rd <= k_rd + 1'b1;
      end
      if (rd_issue) begin
        flight_idx <= k_rd;
      end
    end
  end

  // RAM read port
  assign bus.rd_en   = rd_issue;
  assign bus.rd_sel  = bank_q;
  assign bus.rd_addr = BIT_REV ? N'(bit_reverse(32'(k_rd), N)) : k_rd;

  // Returned word travels with its bin number so the stream index never has
  // to be reconstructed after stalls.
  assign ret_dat = {flight_idx, bus.rd_re, bus.rd_im};

  skid_fifo #(
    .WIDTH(ENTRY_W)
  ) u_skid (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_flight),
    .in_data  (ret_dat),
    .out_valid(head_valid),
    .out_ready(bus.out_ready),
    .out_data (head_dat),
    .count    (fifo_count)
  );

  assign head_idx  = head_dat[ENTRY_W-1 -: N];
  assign head_last = head_valid && (head_idx == LAST_BIN);
  assign transfer  = head_valid && bus.out_ready;

  // Output stream
  assign bus.out_valid = head_valid;
  assign bus.out_index = head_idx;
  assign bus.out_re    = head_dat[2*BIT_WIDTH-1 -: BIT_WIDTH];
  assign bus.out_im    = head_dat[BIT_WIDTH-1:0];
  assign bus.out_last  = head_last;
  assign bus.busy      = busy_c;

endmodule

// File: doc/fft_unload.md
FFT_UNLOAD -- requirements
Module: fft_unload

Interface
REQ-001 Parameter BIT_WIDTH, default 16, width of each real/imag sample word.
REQ-002 Parameter N, default 9, log2 of FFT points (512); addresses are N bits.
REQ-003 Parameter BIT_REV, default 0, 1 = emit bin k from address bitrev(k).
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 fft_done  in  1  level from address generator; a rising edge in IDLE starts unload.
REQ-007 result_bank  in  1  ping-pong bank holding final results; sampled on start.
REQ-008 rd_en  out  1  RAM read strobe; read data valid one cycle later.
REQ-009 rd_addr  out  N  RAM read address.
REQ-010 rd_sel  out  1  bank select for read mux, equals latched result_bank.
REQ-011 rd_re, rd_im  in  BIT_WIDTH each  RAM read data, registered, one-cycle latency after rd_en.
REQ-012 out_valid  out  1  stream data valid.
REQ-013 out_ready  in  1  downstream accept; transfer = out_valid & out_ready.
REQ-014 out_re, out_im  out  BIT_WIDTH each  bin value.
REQ-015 out_index  out  N  bin number k (natural order) of current word.
REQ-016 out_last  out  1  high with bin 2^N-1.
REQ-017 busy  out  1  high from start until final transfer.

Function
REQ-018 States: IDLE, READ (issuing reads), DRAIN (all reads issued, buffer non-empty), DONE (one cycle, then IDLE).
REQ-019 IDLE->READ on the edge where fft_done=1 and its previous-cycle value was 0; latch result_bank; clear index counters.
REQ-020 fft_done edges outside IDLE are ignored; the next unload requires fft_done to fall and rise again.
REQ-021 In READ, rd_en=1 iff buffer occupancy + reads in flight < 2; each issue increments read counter k_rd.
REQ-022 rd_addr = k_rd when BIT_REV=0, else bit-reverse of k_rd over N bits.
REQ-023 READ->DRAIN on the edge issuing k_rd = 2^N-1; no read is issued after it.
REQ-024 Returned data enters a 2-entry skid FIFO together with its bin index; out_* is driven from the FIFO head.
REQ-025 Latency: start edge at cycle t -> rd_en high in cycle t+1 -> out_valid high in cycle t+2 if out_ready is never low.
REQ-026 With out_ready held high, throughput is one bin per cycle; 2^N transfers take 2^N+2 cycles from start.
REQ-027 While out_valid=1 and out_ready=0, out_re, out_im, out_index and out_last hold stable; no data is lost or duplicated.
REQ-028 out_index increments by 1 per transfer, wrapping only at start; out_last = out_valid & (out_index = 2^N-1).
REQ-029 DRAIN->DONE on transfer with out_last; busy falls in DONE; DONE->IDLE unconditionally.
REQ-030 rd_en is never high in IDLE, DRAIN or DONE.

Reset
REQ-031 Reset asserted at any time, including mid-unload: state=IDLE, FIFO empty, in-flight flag cleared, counters 0.
REQ-032 Reset values: rd_en=0, rd_addr=0, rd_sel=0, out_valid=0, out_re=0, out_im=0, out_index=0, out_last=0, busy=0, fft_done edge register=0.
REQ-033 A read returning in the cycle after reset deasserts is discarded.

Structure
REQ-034 The FFT shared package holds BIT_WIDTH/N defaults, the state enum typedef and a bit-reverse function.
REQ-035 The 2-entry skid FIFO is a sub-module named skid_fifo, parameterised by data width.

Verification
REQ-036 RAM model with bank1 word[a] = {re=a, im=~a}, BIT_REV=0, result_bank=1, out_ready=1, fft_done rising at t -> out_valid at t+2, 512 transfers with re=k, last at k=511, busy low by t+515.
REQ-037 BIT_REV=1, same RAM -> bin 1 carries re=256, bin 2 carries re=128, bin 511 carries re=511.
REQ-038 Drive out_ready with a random 50% pattern -> every index 0..511 is received exactly once, in order, and held values stay stable while stalled.
REQ-039 Keep out_ready=0 for 20 cycles after start -> at most 2 reads are issued, out_index=0 is held, and there is no loss after release.
REQ-040 Pulse fft_done again at bin 100 -> no restart; reset at bin 300 -> all outputs match REQ-032 next cycle; a fresh fft_done edge restarts at bin 0.
